// File: rtl/cache_fill_ctrl_if.sv
// Shared main-memory port: one pipelined request per cycle, read data returned in order.
// mem_en is a request that is always accepted (no ready); mem_rvalid marks one in-order read word.
interface cache_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Miss handler and arbiter: serves D stores, D fills and I fills over one pipelined memory port
// and streams returned words into the selected cache data array.
module cache_fill_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WORDS  = 8,
  parameter int IDX_W  = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  cache_fill_ctrl_if.master mem,
  output logic              fill_we,
  output logic              fill_sel,
  output logic [IDX_W-1:0]  fill_idx,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_tag_we,
  output logic              i_done,
  output logic              d_done,
  output logic              d_wr_ack,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Block base clears the byte offset plus the word index bits.
  localparam logic [ADDR_W-1:0] BLK_MASK = ~((ADDR_W'(1) << (IDX_W + 1)) - ADDR_W'(1));
  localparam logic [IDX_W-1:0]  LAST     = IDX_W'(WORDS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  tx_cnt_q, rx_cnt_q;
  logic              grant;
  logic              fill_active;

  logic              mem_en_c, mem_wr_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    grant       = 1'b0;
    mem_en_c    = 1'b0;
    mem_wr_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    d_wr_ack    = 1'b0;
    i_done      = 1'b0;
    d_done      = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated with rst_n so nothing leaves the block while reset is held.
        if (rst_n && d_wr_req) begin
          mem_en_c    = 1'b1;
          mem_wr_c    = 1'b1;
          mem_addr_c  = d_wr_addr;
          mem_wdata_c = d_wr_data;
          d_wr_ack    = 1'b1;
        end else if (rst_n && (d_miss || i_miss)) begin
          grant   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en_c   = 1'b1;
        mem_addr_c = base_q + (ADDR_W'(tx_cnt_q) << 1);
        if (tx_cnt_q == LAST) state_d = DRAIN;
      end
      DRAIN: begin
        if (fill_tag_we) state_d = DONE;
      end
      DONE: begin
        i_done  = ~fill_sel;
        d_done  = fill_sel;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fill_active = (state_q == ISSUE) || (state_q == DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q      <= '0;
      fill_sel    <= 1'b0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      fill_we     <= 1'b0;
      fill_idx    <= '0;
      fill_data   <= '0;
      fill_tag_we <= 1'b0;
    end else begin
      fill_we     <= 1'b0;
      fill_tag_we <= 1'b0;
      if (grant) begin
        base_q   <= (d_miss ? d_miss_addr : i_miss_addr) & BLK_MASK;
        fill_sel <= d_miss;
        tx_cnt_q <= '0;
        rx_cnt_q <= '0;
      end
      if (state_q == ISSUE) tx_cnt_q <= tx_cnt_q + IDX_W'(1);
      // Returns outside a fill are protocol errors and are dropped.
      if (fill_active && mem.mem_rvalid) begin
        fill_we     <= 1'b1;
        fill_idx    <= rx_cnt_q;
        fill_data   <= mem.mem_rdata;
        fill_tag_we <= (rx_cnt_q == LAST);
        rx_cnt_q    <= rx_cnt_q + IDX_W'(1);
      end
    end
  end

  assign mem.mem_en    = mem_en_c;
  assign mem.mem_wr    = mem_wr_c;
  assign mem.mem_addr  = mem_addr_c;
  assign mem.mem_wdata = mem_wdata_c;
  assign busy          = (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule
